// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller host: FSM states,
// poll command word and report field offsets.
package gc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX        = 3'd1,
        RX_WAIT   = 3'd2,
        RX_SAMPLE = 3'd3,
        RX_STOP   = 3'd4,
        DONE      = 3'd5,
        FAIL      = 3'd6
    } gc_state_t;

    localparam logic [23:0] GC_CMD_POLL = 24'h400300;
    localparam int          GC_CMD_BITS = 24;
    localparam int          GC_RSP_BITS = 64;

    // Bit offsets (LSB) of each report field within the 64-bit status word
    localparam int GC_OFS_BUTTONS = 48;
    localparam int GC_OFS_STICK_X = 40;
    localparam int GC_OFS_STICK_Y = 32;
    localparam int GC_OFS_C_X     = 24;
    localparam int GC_OFS_C_Y     = 16;
    localparam int GC_OFS_L_ANA   = 8;
    localparam int GC_OFS_R_ANA   = 0;

    // Byte k of the report, byte 0 being the most significant
    function automatic logic [7:0] gc_report_byte(input logic [63:0] rpt, input logic [2:0] idx);
        logic [5:0] base_s;
        base_s = 6'd63 - {idx, 3'b000};
        return rpt[base_s -: 8];
    endfunction

endpackage

// File: rtl/gc_phy.sv
// Bit-cell engine for the single-wire controller link: open-drain transmitter,
// input synchroniser and receive sample/timeout timer.
module gc_phy
    import gc_pkg::*;
#(
    parameter int US_CYC      = 50,
    parameter int BIT_TMO_CYC = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic line_in,
    output logic line_drv_low,
    input  logic tx_go,
    input  logic tx_bit,
    input  logic tx_last,
    output logic tx_done,
    input  logic rx_wait,
    input  logic rx_samp,
    output logic rx_edge,
    output logic rx_bit,
    output logic rx_valid,
    output logic rx_tmo
);

    localparam int CELL_CYC = 4 * US_CYC;
    localparam int TCW      = $clog2(CELL_CYC);
    localparam int RCW      = $clog2(BIT_TMO_CYC + 2 * US_CYC);

    logic [TCW-1:0] tx_cnt_r;
    logic           tx_act_r;
    logic           tx_bit_r;
    logic           tx_last_r;
    logic           drv_r;
    logic [2:0]     sync_r;
    logic [RCW-1:0] rx_cnt_r;
    logic           low_end_s;
    logic           rx_clr_s;

    // A '1' holds the line low for one microsecond, a '0' for three
    assign low_end_s = tx_act_r &&
                       (tx_cnt_r == (tx_bit_r ? TCW'(US_CYC - 1) : TCW'(3 * US_CYC - 1)));
    // The stop bit completes at the end of its low phase so reception can start at once
    assign tx_done   = tx_act_r &&
                       (tx_last_r ? low_end_s : (tx_cnt_r == TCW'(CELL_CYC - 1)));

    assign line_drv_low = drv_r;
    assign rx_bit       = sync_r[1];
    assign rx_edge      = sync_r[2] & ~sync_r[1];
    assign rx_valid     = rx_samp && (rx_cnt_r == RCW'(2 * US_CYC - 1));
    assign rx_tmo       = rx_wait && (rx_cnt_r == RCW'(BIT_TMO_CYC - 1));
    assign rx_clr_s     = srst || !(rx_wait || rx_samp) || (rx_wait && rx_edge) || rx_valid;

    // Transmit cell timer and open-drain pull-down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_act_r  <= 1'b0;
            tx_bit_r  <= 1'b0;
            tx_last_r <= 1'b0;
            tx_cnt_r  <= {TCW{1'b0}};
            drv_r     <= 1'b0;
        end else if (srst) begin
            tx_act_r  <= 1'b0;
            tx_bit_r  <= 1'b0;
            tx_last_r <= 1'b0;
            tx_cnt_r  <= {TCW{1'b0}};
            drv_r     <= 1'b0;
        end else if (tx_go) begin
            tx_act_r  <= 1'b1;
            tx_bit_r  <= tx_bit;
            tx_last_r <= tx_last;
            tx_cnt_r  <= {TCW{1'b0}};
            drv_r     <= 1'b1;
        end else if (tx_done) begin
            tx_act_r  <= 1'b0;
            tx_cnt_r  <= {TCW{1'b0}};
            drv_r     <= 1'b0;
        end else if (tx_act_r) begin
            tx_cnt_r  <= tx_cnt_r + TCW'(1);
            drv_r     <= drv_r & ~low_end_s;
        end else begin
            drv_r     <= 1'b0;
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[1:0], line_in};
        end
    end

    // Receive timer: restarts on each falling edge and after each sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_r <= {RCW{1'b0}};
        end else if (rx_clr_s) begin
            rx_cnt_r <= {RCW{1'b0}};
        end else begin
            rx_cnt_r <= rx_cnt_r + RCW'(1);
        end
    end

endmodule

// File: rtl/gamecube.sv
// Board top: polls one GameCube controller every POLL_CYC clocks over GPIO[0]
// and shows the latched 64-bit status report on the LEDs.
module gamecube
    import gc_pkg::*;
#(
    parameter int US_CYC      = 50,
    parameter int POLL_CYC    = 50000,
    parameter int BIT_TMO_CYC = 500
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    inout  wire  [35:0] GPIO,
    inout  wire  [6:0]  EXT_IO,
    output logic [17:0] LEDR,
    output logic [8:0]  LEDG
);

    localparam int PCW = $clog2(POLL_CYC);

    gc_state_t   state_r, state_s;
    logic        rst_n_s;
    logic [PCW-1:0] poll_cnt_r;
    logic        poll_go_s;
    logic [23:0] cmd_r;
    logic [23:0] cmd_load_s;
    logic [4:0]  sent_r;
    logic [63:0] shadow_r;
    logic [6:0]  rx_cnt_r;
    logic        stop_seen_r;
    logic [63:0] disp_r;
    logic        valid_r;
    logic        tmo_r;
    logic        busy_r;
    logic        tx_go_s, tx_bit_s, tx_last_s, tx_done_s;
    logic        rx_wait_s, rx_samp_s, rx_edge_s, rx_bit_s, rx_valid_s, rx_tmo_s;
    logic        phy_srst_s;
    logic        drv_low_s;
    logic        unused_s;

    assign rst_n_s    = KEY[1];
    assign cmd_load_s = {GC_CMD_POLL[23:1], SW[17]};
    assign poll_go_s  = (state_r == IDLE) && (poll_cnt_r == PCW'(POLL_CYC - 1));
    assign phy_srst_s = (state_r == DONE) || (state_r == FAIL);

    assign GPIO[0]    = drv_low_s ? 1'b0 : 1'bz;
    assign GPIO[35:1] = {35{1'bz}};
    assign EXT_IO     = {7{1'bz}};
    assign unused_s   = ^{KEY[3:2], KEY[0], SW[16:3]};

    gc_phy #(
        .US_CYC      (US_CYC),
        .BIT_TMO_CYC (BIT_TMO_CYC)
    ) u_phy (
        .clk          (CLOCK_50),
        .rst_n        (rst_n_s),
        .srst         (phy_srst_s),
        .line_in      (GPIO[0]),
        .line_drv_low (drv_low_s),
        .tx_go        (tx_go_s),
        .tx_bit       (tx_bit_s),
        .tx_last      (tx_last_s),
        .tx_done      (tx_done_s),
        .rx_wait      (rx_wait_s),
        .rx_samp      (rx_samp_s),
        .rx_edge      (rx_edge_s),
        .rx_bit       (rx_bit_s),
        .rx_valid     (rx_valid_s),
        .rx_tmo       (rx_tmo_s)
    );

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and PHY handshake decode
    always_comb begin
        state_s   = state_r;
        tx_go_s   = 1'b0;
        tx_bit_s  = 1'b0;
        tx_last_s = 1'b0;
        rx_wait_s = 1'b0;
        rx_samp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (poll_go_s) begin
                    state_s  = TX;
                    tx_go_s  = 1'b1;
                    tx_bit_s = cmd_load_s[23];
                end else begin
                    state_s  = IDLE;
                end
            end
            TX: begin
                if (!tx_done_s) begin
                    state_s = TX;
                end else if (sent_r == 5'(GC_CMD_BITS + 1)) begin
                    state_s = RX_WAIT;
                end else begin
                    tx_go_s   = 1'b1;
                    tx_last_s = (sent_r == 5'(GC_CMD_BITS));
                    tx_bit_s  = tx_last_s | cmd_r[23];
                end
            end
            RX_WAIT: begin
                rx_wait_s = 1'b1;
                if (rx_tmo_s) begin
                    state_s = FAIL;
                end else if (rx_edge_s) begin
                    state_s = RX_SAMPLE;
                end else begin
                    state_s = RX_WAIT;
                end
            end
            RX_SAMPLE: begin
                rx_samp_s = 1'b1;
                if (!rx_valid_s) begin
                    state_s = RX_SAMPLE;
                end else if (rx_cnt_r == 7'(GC_RSP_BITS - 1)) begin
                    state_s = RX_STOP;
                end else begin
                    state_s = RX_WAIT;
                end
            end
            RX_STOP: begin
                rx_wait_s = 1'b1;
                // A missing stop bit is tolerated: the 64 data bits are already complete
                if (rx_tmo_s || (stop_seen_r && rx_bit_s)) begin
                    state_s = DONE;
                end else begin
                    state_s = RX_STOP;
                end
            end
            DONE:    state_s = IDLE;
            FAIL:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Poll gap counter, held at zero outside IDLE so the gap starts after a transaction
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            poll_cnt_r <= {PCW{1'b0}};
        end else if ((state_r == IDLE) && !poll_go_s) begin
            poll_cnt_r <= poll_cnt_r + PCW'(1);
        end else begin
            poll_cnt_r <= {PCW{1'b0}};
        end
    end

    // Command shifter and response shadow register
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cmd_r       <= 24'h000000;
            sent_r      <= 5'd0;
            shadow_r    <= 64'h0;
            rx_cnt_r    <= 7'd0;
            stop_seen_r <= 1'b0;
        end else begin
            if (poll_go_s) begin
                cmd_r    <= {cmd_load_s[22:0], 1'b0};
                sent_r   <= 5'd1;
                shadow_r <= 64'h0;
                rx_cnt_r <= 7'd0;
            end else if ((state_r == TX) && tx_go_s) begin
                cmd_r    <= {cmd_r[22:0], 1'b0};
                sent_r   <= sent_r + 5'd1;
            end else if ((state_r == RX_SAMPLE) && rx_valid_s) begin
                shadow_r <= {shadow_r[62:0], rx_bit_s};
                rx_cnt_r <= rx_cnt_r + 7'd1;
            end else begin
                cmd_r    <= cmd_r;
            end
            stop_seen_r <= (state_r == RX_STOP) && (stop_seen_r || rx_edge_s);
        end
    end

    // Display and status registers driving the LEDs
    always_ff @(posedge CLOCK_50 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            disp_r  <= 64'h0;
            valid_r <= 1'b0;
            tmo_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            if (state_r == DONE) begin
                disp_r  <= shadow_r;
                valid_r <= 1'b1;
                tmo_r   <= 1'b0;
            end else if (state_r == FAIL) begin
                valid_r <= 1'b0;
                tmo_r   <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign LEDR = {busy_r, tmo_r, disp_r[GC_OFS_BUTTONS +: 16]};
    assign LEDG = {valid_r, gc_report_byte(disp_r, SW[2:0])};

endmodule

// File: tb/tb_gamecube.sv
// Directed bench for gamecube: pulled-up data line, behavioural controller
// that times the host command cells and answers with scripted reports.
module tb_gamecube;

    localparam int US   = 50;
    localparam int POLL = 1000;
    localparam int TMO  = 500;
    localparam logic [63:0] RPT1 = 64'h0081_807F_8080_0000;
    localparam logic [63:0] RPT2 = 64'h1FFF_01FE_A55A_C33C;

    logic        clk = 1'b0;
    logic [3:0]  key;
    logic [17:0] sw;
    wire  [35:0] gpio;
    wire  [6:0]  ext_io;
    logic [17:0] ledr;
    logic [8:0]  ledg;
    logic        model_drv;
    int          vec_cnt;
    int          err_cnt;

    assign gpio[0] = model_drv ? 1'b0 : 1'bz;
    pullup (gpio[0]);

    always #10 clk = ~clk;

    gamecube #(
        .US_CYC      (US),
        .POLL_CYC    (POLL),
        .BIT_TMO_CYC (TMO)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .GPIO     (gpio),
        .EXT_IO   (ext_io),
        .LEDR     (ledr),
        .LEDG     (ledg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_to_low(input int budget, output int n);
        n = 0;
        while (gpio[0] !== 1'b0 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        while (ledr[17] !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    // Decode 24 command cells plus stop; counts cells with wrong low/high lengths
    task automatic host_rx(output logic [24:0] bits, output int bad);
        bits = 25'h0;
        bad  = 0;
        for (int i = 0; i < 25; i++) begin
            int w;
            int lo;
            int hi;
            w = 0;
            while (gpio[0] !== 1'b0 && w < 400) begin
                step();
                w++;
            end
            lo = 0;
            while (gpio[0] === 1'b0 && lo < 400) begin
                step();
                lo++;
            end
            bits = {bits[23:0], (lo < 100)};
            if (i < 24) begin
                hi = 0;
                while (gpio[0] !== 1'b0 && hi < 400) begin
                    step();
                    hi++;
                end
                if (bits[0] ? (lo != US || hi != 3 * US) : (lo != 3 * US || hi != US)) bad++;
            end else if (lo != US) begin
                bad++;
            end
        end
    endtask

    task automatic reply(input logic [63:0] d, input int nbits);
        repeat (100) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            int lo;
            lo = d[63 - i] ? US : 3 * US;
            model_drv = 1'b1;
            repeat (lo) @(negedge clk);
            model_drv = 1'b0;
            repeat (4 * US - lo) @(negedge clk);
        end
        if (nbits == 64) begin
            model_drv = 1'b1;
            repeat (US) @(negedge clk);
            model_drv = 1'b0;
        end
    endtask

    initial begin
        logic [24:0] bits;
        int          bad;
        int          n;
        vec_cnt   = 0;
        err_cnt   = 0;
        model_drv = 1'b0;
        sw        = 18'h00000;
        key       = 4'b1111;
        #5 key[1] = 1'b0;
        #245;
        check("rst_line", 64'(gpio[0]), 64'd1);
        check("rst_ledr", 64'(ledr), 64'h0);
        check("rst_ledg", 64'(ledg), 64'h0);
        #255;
        @(negedge clk);
        key[1] = 1'b1;

        count_to_low(POLL + 10, n);
        check("first_poll_delay", 64'(n), 64'(POLL));
        host_rx(bits, bad);
        check("cmd_rumble0", 64'(bits), 64'({24'h400300, 1'b1}));
        check("tx_cell_timing", 64'(bad), 64'd0);
        reply(RPT1, 64);
        wait_idle("done1_bound", 100, n);
        check("ledr_rpt1", 64'(ledr), 64'({2'b00, 16'h0081}));
        check("ledg_valid1", 64'(ledg[8]), 64'd1);
        sw[2:0] = 3'd2;
        #1 check("ledg_byte2", 64'(ledg[7:0]), 64'h80);
        sw[2:0] = 3'd3;
        #1 check("ledg_byte3", 64'(ledg[7:0]), 64'h7F);

        sw[17] = 1'b1;
        count_to_low(POLL + 10, n);
        check("poll_gap_done", 64'(n), 64'(POLL));
        host_rx(bits, bad);
        check("cmd_rumble1", 64'(bits), 64'({24'h400301, 1'b1}));
        wait_idle("tmo_bound", 800, n);
        check("tmo_latency", 64'(n >= TMO && n <= TMO + 3), 64'd1);
        check("ledr_tmo", 64'(ledr), 64'({2'b01, 16'h0081}));
        check("ledg_tmo", 64'(ledg[8]), 64'd0);

        sw[17] = 1'b0;
        count_to_low(POLL + 10, n);
        check("poll_gap_fail", 64'(n), 64'(POLL));
        host_rx(bits, bad);
        reply(RPT1, 40);
        wait_idle("partial_bound", 800, n);
        check("ledr_partial", 64'(ledr), 64'({2'b01, 16'h0081}));
        check("ledg_partial", 64'(ledg[8]), 64'd0);

        count_to_low(POLL + 10, n);
        host_rx(bits, bad);
        check("cmd_after_fail", 64'(bits), 64'({24'h400300, 1'b1}));
        reply(RPT2, 64);
        wait_idle("done2_bound", 100, n);
        check("ledr_rpt2", 64'(ledr), 64'({2'b00, 16'h1FFF}));
        check("ledg_valid2", 64'(ledg[8]), 64'd1);
        sw[2:0] = 3'd7;
        #1 check("ledg_byte7", 64'(ledg[7:0]), 64'h3C);
        sw[2:0] = 3'd4;
        #1 check("ledg_byte4", 64'(ledg[7:0]), 64'hA5);

        count_to_low(POLL + 10, n);
        check("line_low_pre_rst", 64'(gpio[0]), 64'd0);
        @(negedge clk);
        key[1] = 1'b0;
        #1;
        check("mid_rst_line", 64'(gpio[0]), 64'd1);
        check("mid_rst_ledr", 64'(ledr), 64'h0);
        check("mid_rst_ledg", 64'(ledg), 64'h0);
        #100;
        @(negedge clk);
        key[1] = 1'b1;
        count_to_low(POLL + 10, n);
        check("restart_poll_delay", 64'(n), 64'(POLL));
        host_rx(bits, bad);
        check("restart_cmd", 64'(bits), 64'({24'h400300, 1'b1}));
        check("restart_cell_timing", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
